io_handshake_unit: RTL and testbench
====================================

# io_handshake_unit

Responder side of the processor's IN/OUT instruction protocol. When the control unit decodes IN, it drops its clock enable and asserts `In`. This block holds the processor stalled until the operator makes a debounced press of the pushbutton. It then captures the switch value as `InData` and releases the processor for exactly one instruction. It also owns the output display register written by OUT, and sits between the control unit and the board switches, button and display.

## Interface
Parameters:
- `DATA_W`, 32, datapath and display width.
- `SW_W`, 16, switch bank width. Must satisfy `SW_W` ≤ `DATA_W`.
- `DEBOUNCE_CYCLES`, 50000, number of consecutive stable samples needed to accept a button change. Must be ≥ 1.

Ports:
- `clock`  in  1  single system clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `In`  in  1  IN request from control unit; level, held while IN is the current instruction.
- `Out`  in  1  OUT request from control unit; level.
- `Button`  in  1  raw pushbutton, asynchronous, pressed = 1.
- `Switches`  in  SW_W  raw switch bank, quasi-static.
- `OutData`  in  DATA_W  register-file value to display.
- `InData`  out  DATA_W  captured switch value, zero-extended.
- `InValid`  out  1  one-cycle pulse marking the cycle in which `InData` was captured.
- `CpuEnable`  out  1  processor may advance on the next edge.
- `Display`  out  DATA_W  held display value.

## Operation
Button path:
- Two-flop synchronizer feeds a debouncer that holds a clean level.
- Debounce counter clears whenever the synchronized sample equals the clean level, and increments otherwise.
- After `DEBOUNCE_CYCLES` consecutive differing samples, the clean level toggles and the counter clears.
- `press` is a one-cycle pulse on each clean 0→1 transition.

FSM states: IDLE, WAIT_RELEASE, WAIT_PRESS, CAPTURE, HOLD.
- IDLE: if `In`=1 and the clean level is 1, go to WAIT_RELEASE (a press already in progress does not count). If `In`=1 and the clean level is 0, go to WAIT_PRESS.
- WAIT_RELEASE: when the clean level is 0, go to WAIT_PRESS.
- WAIT_PRESS: on `press`, go to CAPTURE.
- CAPTURE: one cycle. Register `InData` ← zero-extended `Switches` at the edge leaving this state. `InValid`=1. Then go to HOLD.
- HOLD: stay while `In`=1; when `In`=0, go to IDLE. HOLD guarantees one press produces one capture, even with back-to-back IN instructions.
- In WAIT_RELEASE or WAIT_PRESS, if `In`=0, go to IDLE without capturing.

`CpuEnable` is combinational:
- IDLE: equals `!In`, so the stall takes effect in the same cycle `In` rises.
- WAIT_RELEASE, WAIT_PRESS: 0.
- CAPTURE, HOLD: 1.

Display:
- On every edge with `Out`=1 and `In`=0, `Display` ← `OutData`.
- `Out` is ignored while `In`=1, because IN asserts both.

## Timing
- Reset values: state IDLE; `InData`=0; `Display`=0; `InValid`=0; synchronizer, clean level and counter all 0. `CpuEnable` is `!In` while in reset.
- Button latency: edge t is the first to sample `Button`=1, and the button is held stable with the FSM in WAIT_PRESS. `press` is high in the cycle after edge t+1+`DEBOUNCE_CYCLES`. CAPTURE follows, and `CpuEnable`/`InValid` are high in the cycle after edge t+2+`DEBOUNCE_CYCLES`.
- `InData` is valid from the edge following the `InValid` cycle and holds until the next capture.
- A bounce shorter than `DEBOUNCE_CYCLES` samples never changes the clean level.
- Display write latency: 1 edge.
- If `reset` is asserted mid-stall, the block returns to IDLE immediately and any partial debounce is discarded.

## Configuration
- `IO_ECHO_EN` defined: in CAPTURE, `Display` also loads zero-extended `Switches` on the same edge as `InData`.
- `IO_ECHO_EN` undefined: `Display` changes only through `Out`.

## Structure
- Shared package holds the FSM state enum and a `SW_ZEXT` width-extension helper constant. Both are reused by the top-level board wrapper.
- One sub-module, `button_debouncer`: synchronizer, counter and clean level. Parameter `DEBOUNCE_CYCLES`; outputs `level` and `press`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset release with `In`=0 → `CpuEnable`=1, `Display`=0, `InData`=0.
- `In`=1, `Switches`=16'h00A5, clean press starting at edge t → `CpuEnable` stays 0 until the cycle after edge t+6, then `InValid` pulses once and `InData`=32'h000000A5.
- `Button` held high before `In` rises → no capture until release then a new press. `CpuEnable`=0 throughout.
- `Button` bouncing 1-1-1-0 repeatedly while `In`=1 → no capture and `CpuEnable`=0. After 4 stable high samples, capture occurs.
- `Out`=1, `In`=0, `OutData`=32'hDEADBEEF → `Display`=32'hDEADBEEF after one edge. With `Out`=1, `In`=1 → `Display` unchanged, except for the echo value when `IO_ECHO_EN` is defined.
- `reset` asserted during WAIT_PRESS → IDLE immediately. After reset release with `In`=1, the block re-enters WAIT_PRESS and requires a full new debounced press.

Source files
------------

// File: rtl/io_handshake_unit_pkg.sv
// Shared definitions for the IN/OUT handshake responder and its board wrapper:
// the handshake FSM state encoding and the default switch zero-extension width.
package io_handshake_unit_pkg;

  // Handshake FSM states
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_RELEASE = 3'd1,
    WAIT_PRESS   = 3'd2,
    CAPTURE      = 3'd3,
    HOLD         = 3'd4
  } ioState_t;

  // Default datapath and switch widths used by the board wrapper
  localparam int DATA_W_DEFAULT = 32;
  localparam int SW_W_DEFAULT   = 16;

  // Number of zero bits prepended to the switch bank to fill the datapath
  localparam int SW_ZEXT = DATA_W_DEFAULT - SW_W_DEFAULT;

endpackage

// File: rtl/io_handshake_unit_button_debouncer.sv
// Pushbutton conditioning: two-flop synchronizer, run-length debouncer holding a
// clean level, and a one-cycle press pulse on every clean rising transition.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic press
);

  // Wide enough to hold DEBOUNCE_CYCLES-1, with at least one bit
  localparam int CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            syncMetaReg;
  logic            syncOutReg;
  logic            levelReg;
  logic            pressReg;
  logic [CntW-1:0] cntReg;

  // Synchronize the raw button, count consecutive samples that disagree with the
  // clean level, and flip the level once the disagreement has lasted long enough
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncMetaReg <= 1'b0;
      syncOutReg  <= 1'b0;
      levelReg    <= 1'b0;
      pressReg    <= 1'b0;
      cntReg      <= '0;
    end else begin
      syncMetaReg <= button;
      syncOutReg  <= syncMetaReg;
      pressReg    <= 1'b0;
      if (syncOutReg == levelReg) begin
        cntReg <= '0;
      end else if (cntReg == CntLast) begin
        // A toggle from 0 is a press; the pulse lines up with the new level
        levelReg <= ~levelReg;
        pressReg <= ~levelReg;
        cntReg   <= '0;
      end else begin
        cntReg <= cntReg + 1'b1;
      end
    end
  end

  assign level = levelReg;
  assign press = pressReg;

endmodule

// File: rtl/io_handshake_unit.sv
// Responder for the processor's IN/OUT protocol. IN stalls the CPU until a clean
// button press, then captures the switches and releases exactly one instruction.
// OUT writes the display register.
// Optional feature macro IO_ECHO_EN: when defined, a capture also copies the
// zero-extended switches into the display.
// SW_W must not exceed DATA_W; DEBOUNCE_CYCLES must be at least 1.
module io_handshake_unit
  import io_handshake_unit_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              In,
  input  logic              Out,
  input  logic              Button,
  input  logic [SW_W-1:0]   Switches,
  input  logic [DATA_W-1:0] OutData,
  output logic [DATA_W-1:0] InData,
  output logic              InValid,
  output logic              CpuEnable,
  output logic [DATA_W-1:0] Display
);

  ioState_t          stateReg;
  logic [DATA_W-1:0] inDataReg;
  logic              inValidReg;
  logic [DATA_W-1:0] displayReg;
  logic              cleanLevel;
  logic              press;
  logic [DATA_W-1:0] switchesExt;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) uDebouncer (
    .clock (clock),
    .reset (reset),
    .button(Button),
    .level (cleanLevel),
    .press (press)
  );

  assign switchesExt = DATA_W'(Switches);

  // Handshake FSM; InValid is registered so it is high exactly while in CAPTURE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg   <= IDLE;
      inDataReg  <= '0;
      inValidReg <= 1'b0;
    end else begin
      inValidReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          // A button already held when IN arrives must be released first
          if (In) begin
            stateReg <= cleanLevel ? WAIT_RELEASE : WAIT_PRESS;
          end
        end
        WAIT_RELEASE: begin
          if (!In) begin
            stateReg <= IDLE;
          end else if (!cleanLevel) begin
            stateReg <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (!In) begin
            stateReg <= IDLE;
          end else if (press) begin
            stateReg   <= CAPTURE;
            inValidReg <= 1'b1;
          end
        end
        CAPTURE: begin
          inDataReg <= switchesExt;
          stateReg  <= HOLD;
        end
        HOLD: begin
          // Parked until the IN instruction retires, so one press gives one capture
          if (!In) begin
            stateReg <= IDLE;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  // Display register: OUT writes it unless an IN is in progress
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      displayReg <= '0;
    end else begin
      if (Out && !In) begin
        displayReg <= OutData;
      end
`ifdef IO_ECHO_EN
      if (stateReg == CAPTURE) begin
        displayReg <= switchesExt;
      end
`endif
    end
  end

  // CPU enable: stall in the same cycle IN rises, release once captured
  always_comb begin
    CpuEnable = 1'b0;
    case (stateReg)
      IDLE:                       CpuEnable = !In;
      WAIT_RELEASE, WAIT_PRESS:   CpuEnable = 1'b0;
      CAPTURE, HOLD:              CpuEnable = 1'b1;
      default:                    CpuEnable = 1'b0;
    endcase
  end

  assign InData  = inDataReg;
  assign InValid = inValidReg;
  assign Display = displayReg;

endmodule

// File: tb/tb_io_handshake_unit.sv
// Bench for io_handshake_unit with DEBOUNCE_CYCLES=4. Inputs are driven and
// outputs sampled on the falling clock edge; expected captures go through a queue.
module tb_io_handshake_unit;

  localparam int DATA_W = 32;
  localparam int SW_W   = 16;
  localparam int DEB    = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              In;
  logic              Out;
  logic              Button;
  logic [SW_W-1:0]   Switches;
  logic [DATA_W-1:0] OutData;
  logic [DATA_W-1:0] InData;
  logic              InValid;
  logic              CpuEnable;
  logic [DATA_W-1:0] Display;

  logic [DATA_W-1:0] expQ[$];
  logic [DATA_W-1:0] expData;
  int checkCount = 0;
  int passCount  = 0;

  io_handshake_unit #(
    .DATA_W(DATA_W),
    .SW_W(SW_W),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .In       (In),
    .Out      (Out),
    .Button   (Button),
    .Switches (Switches),
    .OutData  (OutData),
    .InData   (InData),
    .InValid  (InValid),
    .CpuEnable(CpuEnable),
    .Display  (Display)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Drop IN and the button, and let the debouncer settle back to 0
  task automatic settle();
    In = 1'b0;
    Button = 1'b0;
    idleCycles(10);
  endtask

  task automatic test_reset();
    checkCount++;
    if (CpuEnable !== 1'b1 || Display !== '0 || InData !== '0 || InValid !== 1'b0) begin
      $display("FAIL reset_state: got en=%b disp=%h data=%h valid=%b required en=1 disp=0 data=0 valid=0",
               CpuEnable, Display, InData, InValid);
    end else passCount++;
    $display("reset: en=%b disp=%h data=%h", CpuEnable, Display, InData);
  endtask

  task automatic test_capture();
    int bad;
    Switches = 16'h00A5;
    In = 1'b1;
    #1;
    checkCount++;
    if (CpuEnable !== 1'b0) $display("FAIL stall_same_cycle: got en=%b required 0", CpuEnable);
    else passCount++;
    @(negedge clock);
    expQ.push_back(32'h0000_00A5);
    Button = 1'b1;
    // Cycle after edge t+k for k=0..6: capture only after edge t+6
    for (int k = 0; k <= DEB + 2; k++) begin
      @(negedge clock);
      checkCount++;
      if (k < DEB + 2) begin
        if (CpuEnable !== 1'b0 || InValid !== 1'b0)
          $display("FAIL capture_latency_k%0d: got en=%b valid=%b required en=0 valid=0", k, CpuEnable, InValid);
        else passCount++;
      end else begin
        if (CpuEnable !== 1'b1 || InValid !== 1'b1)
          $display("FAIL capture_latency_k%0d: got en=%b valid=%b required en=1 valid=1", k, CpuEnable, InValid);
        else passCount++;
      end
    end
    @(negedge clock);
    expData = (expQ.size() > 0) ? expQ.pop_front() : 'x;
    checkCount++;
    if (InData !== expData || InValid !== 1'b0 || CpuEnable !== 1'b1)
      $display("FAIL capture_data: got data=%h valid=%b en=%b required data=%h valid=0 en=1",
               InData, InValid, CpuEnable, expData);
    else passCount++;
    $display("capture: switches=%h data=%h", Switches, InData);
    // Second press while the same IN is still active must not capture again
    bad = 0;
    Button = 1'b0;
    idleCycles(8);
    Button = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (InValid !== 1'b0 || CpuEnable !== 1'b1) bad++;
    end
    checkCount++;
    if (bad != 0) $display("FAIL hold_no_recapture: got %0d bad cycles required 0", bad);
    else passCount++;
    $display("hold: repeated press during one IN, bad cycles=%0d", bad);
    settle();
  endtask

  task automatic test_held_button();
    int bad;
    Button = 1'b1;
    idleCycles(10);
    In = 1'b1;
    #1;
    checkCount++;
    if (CpuEnable !== 1'b0) $display("FAIL held_stall: got en=%b required 0", CpuEnable);
    else passCount++;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (CpuEnable !== 1'b0 || InValid !== 1'b0) bad++;
    end
    Button = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (CpuEnable !== 1'b0 || InValid !== 1'b0) bad++;
    end
    checkCount++;
    if (bad != 0) $display("FAIL held_no_capture: got %0d bad cycles required 0", bad);
    else passCount++;
    Switches = 16'hBEEF;
    expQ.push_back(32'h0000_BEEF);
    Button = 1'b1;
    for (int k = 0; k <= DEB + 2; k++) begin
      @(negedge clock);
      if (k < DEB + 2 && (InValid !== 1'b0 || CpuEnable !== 1'b0)) bad++;
    end
    checkCount++;
    if (bad != 0 || InValid !== 1'b1 || CpuEnable !== 1'b1)
      $display("FAIL held_new_press: got valid=%b en=%b early=%0d required valid=1 en=1 early=0",
               InValid, CpuEnable, bad);
    else passCount++;
    @(negedge clock);
    expData = (expQ.size() > 0) ? expQ.pop_front() : 'x;
    checkCount++;
    if (InData !== expData) $display("FAIL held_data: got %h required %h", InData, expData);
    else passCount++;
    $display("held_button: data=%h", InData);
    settle();
  endtask

  task automatic test_bounce();
    int bad;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b0;
    Switches = 16'h1234;
    In = 1'b1;
    @(negedge clock);
    bad = 0;
    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < 4; b++) begin
        Button = pat[b];
        @(negedge clock);
        if (CpuEnable !== 1'b0 || InValid !== 1'b0) bad++;
      end
    end
    checkCount++;
    if (bad != 0) $display("FAIL bounce_rejected: got %0d bad cycles required 0", bad);
    else passCount++;
    expQ.push_back(32'h0000_1234);
    Button = 1'b1;
    bad = 0;
    for (int k = 0; k <= DEB + 2; k++) begin
      @(negedge clock);
      if (k < DEB + 2 && InValid !== 1'b0) bad++;
    end
    checkCount++;
    if (bad != 0 || InValid !== 1'b1)
      $display("FAIL bounce_then_stable: got valid=%b early=%0d required valid=1 early=0", InValid, bad);
    else passCount++;
    @(negedge clock);
    expData = (expQ.size() > 0) ? expQ.pop_front() : 'x;
    checkCount++;
    if (InData !== expData) $display("FAIL bounce_data: got %h required %h", InData, expData);
    else passCount++;
    $display("bounce: data=%h", InData);
    settle();
  endtask

  task automatic test_display();
    logic [DATA_W-1:0] expDisp;
    int seen;
    Out = 1'b1;
    OutData = 32'hDEAD_BEEF;
    @(negedge clock);
    checkCount++;
    if (Display !== 32'hDEAD_BEEF) $display("FAIL display_write: got %h required deadbeef", Display);
    else passCount++;
    $display("display: out write -> %h", Display);
    In = 1'b1;
    OutData = 32'h1234_5678;
    @(negedge clock);
    checkCount++;
    if (Display !== 32'hDEAD_BEEF) $display("FAIL display_in_masks_out: got %h required deadbeef", Display);
    else passCount++;
    Switches = 16'h5A3C;
    expQ.push_back(32'h0000_5A3C);
    Button = 1'b1;
    seen = 0;
    for (int k = 0; k < 15 && seen == 0; k++) begin
      @(negedge clock);
      if (InValid === 1'b1) seen = 1;
    end
    checkCount++;
    if (seen == 0) $display("FAIL display_capture_timeout: got no InValid required one within 15 cycles");
    else passCount++;
    Out = 1'b0;
    @(negedge clock);
    expData = (expQ.size() > 0) ? expQ.pop_front() : 'x;
`ifdef IO_ECHO_EN
    expDisp = 32'h0000_5A3C;
`else
    expDisp = 32'hDEAD_BEEF;
`endif
    checkCount++;
    if (InData !== expData || Display !== expDisp)
      $display("FAIL display_after_capture: got data=%h disp=%h required data=%h disp=%h",
               InData, Display, expData, expDisp);
    else passCount++;
    $display("display: after capture data=%h disp=%h", InData, Display);
    settle();
  endtask

  task automatic test_reset_midstall();
    int bad;
    In = 1'b1;
    @(negedge clock);
    Button = 1'b1;
    idleCycles(3);
    reset = 1'b1;
    #1;
    checkCount++;
    if (InData !== '0 || Display !== '0 || InValid !== 1'b0 || CpuEnable !== 1'b0)
      $display("FAIL reset_async: got data=%h disp=%h valid=%b en=%b required data=0 disp=0 valid=0 en=0",
               InData, Display, InValid, CpuEnable);
    else passCount++;
    idleCycles(2);
    Switches = 16'h0F0F;
    expQ.push_back(32'h0000_0F0F);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k <= DEB + 2; k++) begin
      @(negedge clock);
      if (k < DEB + 2 && (InValid !== 1'b0 || CpuEnable !== 1'b0)) bad++;
    end
    checkCount++;
    if (bad != 0 || InValid !== 1'b1)
      $display("FAIL reset_full_debounce: got valid=%b early=%0d required valid=1 early=0", InValid, bad);
    else passCount++;
    @(negedge clock);
    expData = (expQ.size() > 0) ? expQ.pop_front() : 'x;
    checkCount++;
    if (InData !== expData) $display("FAIL reset_capture_data: got %h required %h", InData, expData);
    else passCount++;
    $display("reset_midstall: data=%h", InData);
    settle();
  endtask

  initial begin
    reset = 1'b1;
    In = 1'b0;
    Out = 1'b0;
    Button = 1'b0;
    Switches = '0;
    OutData = '0;
    idleCycles(3);
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_capture();
    test_held_button();
    test_bounce();
    test_display();
    test_reset_midstall();
    checkCount++;
    if (expQ.size() != 0) $display("FAIL scoreboard_empty: got %0d pending required 0", expQ.size());
    else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
